// File: rtl/spi_sram_responder.sv
// SPI SRAM responder (23LC1024-style READ/WRITE/RDMR/WRMR) clocked directly by the SPI bit clock.
// Decodes cs_n/mosi, drives a registered miso and issues one-cycle accesses on a synchronous memory port.
//
// state  | meaning
// CMD    | shifting in the 8-bit command
// ADDR   | shifting in the 24-bit start address
// RDATA  | streaming read bytes out on miso
// WDATA  | collecting write bytes from mosi
// RDMR   | looping the mode register out on miso
// WRMR   | collecting the new mode byte
// IGNORE | idle until deselect
module spi_sram_responder #(
   parameter int ADDR_WIDTH = 24,
   parameter int PAGE_BYTES = 32
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_en,
   output logic                  mem_wr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata
);

   localparam int PW = $clog2(PAGE_BYTES);

   typedef enum logic [2:0] {
      S_CMD, S_ADDR, S_RDATA, S_WDATA, S_RDMR, S_WRMR, S_IGNORE
   } state_t;

   state_t                state, state_d;
   logic [2:0]            bit_cnt;
   logic [1:0]            addr_byte;
   logic                  is_read;
   logic [6:0]            rx_sh;
   logic [7:0]            tx_sh;
   logic [7:0]            mode;
   logic [ADDR_WIDTH-2:0] addr_sh;
   logic [ADDR_WIDTH-1:0] nxt_addr;

   logic [7:0]            rx_byte;
   logic [ADDR_WIDTH-1:0] base;
   logic                  last_bit, addr_done, byte_mode, page_mode;
   logic                  strobe, strobe_wr, miso_d;
   logic [ADDR_WIDTH-1:0] strobe_addr;

   assign rx_byte   = {rx_sh, mosi};
   assign base      = {addr_sh, mosi};
   assign last_bit  = (bit_cnt == 3'd7);
   assign addr_done = (state == S_ADDR) && last_bit && (addr_byte == 2'd2);
   assign byte_mode = (mode[7:6] == 2'b00);
   assign page_mode = (mode[7:6] == 2'b10);

   // Page mode keeps the bits above the page offset fixed so the offset wraps.
   function automatic logic [ADDR_WIDTH-1:0] incr(input logic [ADDR_WIDTH-1:0] a, input logic page);
      logic [ADDR_WIDTH-1:0] r;
      r = a + 1'b1;
      if (page) r[ADDR_WIDTH-1:PW] = a[ADDR_WIDTH-1:PW];
      return r;
   endfunction

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= S_CMD;
      else         state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (cs_n) begin
         state_d = S_CMD;
      end else begin
         case (state)
            S_CMD: if (last_bit) begin
               case (rx_byte)
                  8'h03, 8'h02: state_d = S_ADDR;
                  8'h05:        state_d = S_RDMR;
                  8'h01:        state_d = S_WRMR;
                  default:      state_d = S_IGNORE;
               endcase
            end
            S_ADDR:           if (addr_done) state_d = is_read ? S_RDATA : S_WDATA;
            S_RDATA, S_WDATA: if (last_bit && byte_mode) state_d = S_IGNORE;
            S_WRMR:           if (last_bit) state_d = S_IGNORE;
            default:          state_d = state;
         endcase
      end
   end

   always_comb begin
      strobe      = 1'b0;
      strobe_wr   = 1'b0;
      strobe_addr = nxt_addr;
      miso_d      = 1'b0;
      if (!cs_n) begin
         case (state)
            S_CMD:   if (last_bit && rx_byte == 8'h05) miso_d = mode[7];
            S_ADDR:  if (addr_done && is_read) begin
               strobe      = 1'b1;
               strobe_addr = base;
            end
            S_RDATA: begin
               miso_d = (bit_cnt == 3'd0) ? mem_rdata[7] : tx_sh[7];
               strobe = last_bit && !byte_mode;
            end
            S_WDATA: begin
               strobe    = last_bit;
               strobe_wr = 1'b1;
            end
            S_RDMR:  miso_d = mode[3'd6 - bit_cnt];
            default: miso_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         miso      <= 1'b0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
         mode      <= 8'h40;
         bit_cnt   <= 3'd0;
         addr_byte <= 2'd0;
         is_read   <= 1'b0;
         rx_sh     <= 7'h00;
         tx_sh     <= 8'h00;
         addr_sh   <= '0;
         nxt_addr  <= '0;
      end else begin
         mem_en <= strobe;
         miso   <= miso_d;
         if (strobe) begin
            mem_addr <= strobe_addr;
            mem_wr   <= strobe_wr;
            nxt_addr <= incr(strobe_addr, page_mode);
            if (strobe_wr) mem_wdata <= rx_byte;
         end
         if (cs_n) begin
            bit_cnt <= 3'd0;
         end else begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sh   <= rx_byte[6:0];
            if (state == S_CMD && last_bit) begin
               is_read   <= (rx_byte == 8'h03);
               addr_byte <= 2'd0;
            end
            if (state == S_ADDR) begin
               addr_sh <= base[ADDR_WIDTH-2:0];
               if (last_bit) addr_byte <= addr_byte + 2'd1;
            end
            if (addr_done && !is_read) nxt_addr <= base;
            if (state == S_RDATA)
               tx_sh <= (bit_cnt == 3'd0) ? {mem_rdata[6:0], 1'b0} : {tx_sh[6:0], 1'b0};
            if (state == S_WRMR && last_bit) mode <= {rx_byte[7:6], 6'b0};
         end
      end
   end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: directed scenarios plus random transactions, each checked
// against a transaction-level model of strobes, write data, miso bytes and the mode register.
module tb_spi_sram_responder;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso, mem_en, mem_wr;
   logic [23:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   logic [7:0]  mem [1024];
   logic [7:0]  ref_mem [1024];
   logic [7:0]  mode_m;
   logic [7:0]  tx_q [$];
   int          n_chk = 0;
   int          n_pass = 0;

   typedef struct packed {
      logic [15:0] edge_i;
      logic [23:0] addr;
      logic        wr;
      logic [7:0]  wdata;
   } strobe_t;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:0]];

   spi_sram_responder #(.ADDR_WIDTH(24), .PAGE_BYTES(32)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .mem_addr  (mem_addr),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Address of byte n of a burst, straight from the mode rules.
   function automatic logic [23:0] addr_n(input logic [23:0] base, input int n, input logic [1:0] m);
      int b;
      b = int'(base);
      if (m == 2'b10) return 24'((b / 32) * 32 + ((b % 32) + n) % 32);
      return 24'((b + n) % (1 << 24));
   endfunction

   task automatic xfer(input int nb);
      strobe_t     exp_q [$];
      strobe_t     got_q [$];
      logic        got_bits [$];
      strobe_t     s;
      logic [7:0]  cmd, d, gb, eb;
      logic [23:0] base, a;
      logic [1:0]  m;
      logic        rd, wr, rm, prev_en, ebit;
      int          viol, nc, n;
      while (tx_q.size() < nb / 8 + 5) tx_q.push_back(8'($urandom));
      cmd  = tx_q[0];
      base = {tx_q[1], tx_q[2], tx_q[3]};
      m    = mode_m[7:6];
      rd   = (nb >= 8) && (cmd == 8'h03);
      wr   = (nb >= 8) && (cmd == 8'h02);
      rm   = (nb >= 8) && (cmd == 8'h05);
      if (rd)
         for (int i = 0; 31 + 8 * i <= nb - 1; i++)
            if (m != 2'b00 || i == 0) begin
               s.edge_i = 16'(31 + 8 * i); s.addr = addr_n(base, i, m); s.wr = 1'b0; s.wdata = 8'h00;
               exp_q.push_back(s);
            end
      if (wr)
         for (int i = 0; 39 + 8 * i <= nb - 1; i++)
            if (m != 2'b00 || i == 0) begin
               s.edge_i = 16'(39 + 8 * i); s.addr = addr_n(base, i, m); s.wr = 1'b1; s.wdata = tx_q[4 + i];
               exp_q.push_back(s);
            end
      prev_en = 1'b0;
      viol = 0;
      for (int k = 0; k < nb; k++) begin
         @(negedge clk);
         cs_n = 1'b0;
         d = tx_q[k / 8];
         mosi = d[7 - (k % 8)];
         @(posedge clk);
         #1;
         if (mem_en) begin
            s.edge_i = 16'(k); s.addr = mem_addr; s.wr = mem_wr; s.wdata = mem_wr ? mem_wdata : 8'h00;
            got_q.push_back(s);
            if (mem_wr) mem[mem_addr[9:0]] = mem_wdata;
         end
         if (mem_en && prev_en) viol++;
         prev_en = mem_en;
         got_bits.push_back(miso);
      end
      @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'($urandom);
      @(posedge clk);
      #1;
      check("deselect_idle", 64'({miso, mem_en}), 64'(0));
      check("n_strobe", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check("strobe", 64'(got_q[i]), 64'(exp_q[i]));
      gb = 8'h00; eb = 8'h00; nc = 0;
      for (int e = 1; e <= nb; e++) begin
         ebit = 1'b0;
         if (rd && e >= 33) begin
            n = (e - 33) / 8;
            if (m != 2'b00 || n == 0) begin
               a = addr_n(base, n, m);
               d = ref_mem[a[9:0]];
               ebit = d[7 - ((e - 33) % 8)];
            end
         end else if (rm && e >= 8) begin
            ebit = mode_m[7 - ((e - 8) % 8)];
         end
         gb = {gb[6:0], got_bits[e - 1]};
         eb = {eb[6:0], ebit};
         nc++;
         if (nc == 8 || e == nb) begin
            check("miso", 64'(gb), 64'(eb));
            gb = 8'h00; eb = 8'h00; nc = 0;
         end
      end
      check("en_pulse", 64'(viol), 64'(0));
      foreach (exp_q[i]) if (exp_q[i].wr) ref_mem[exp_q[i].addr[9:0]] = exp_q[i].wdata;
      if (cmd == 8'h01 && nb >= 16) begin
         d = tx_q[1];
         mode_m = {d[7:6], 6'b0};
      end
      tx_q.delete();
   endtask

   task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5, input int nb);
      tx_q.delete();
      tx_q.push_back(b0); tx_q.push_back(b1); tx_q.push_back(b2);
      tx_q.push_back(b3); tx_q.push_back(b4); tx_q.push_back(b5);
      xfer(nb);
   endtask

   initial begin
      logic [7:0]  d, cmd;
      logic [23:0] base;
      int          nb, nbytes;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[10'h234] = 8'hA5; ref_mem[10'h234] = 8'hA5;
      mem[10'h235] = 8'h3C; ref_mem[10'h235] = 8'h3C;
      mode_m = 8'h40;

      #12;
      check("reset_outputs", 64'({miso, mem_en, mem_wr, mem_addr, mem_wdata}), 64'(0));
      @(negedge clk);
      arst_n = 1'b1;

      send(8'h03, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 48);
      send(8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h22, 48);
      send(8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 16);
      send(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24);
      send(8'h03, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00, 48);
      send(8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 16);
      send(8'h02, 8'h00, 8'h00, 8'h50, 8'h5A, 8'hC3, 44);
      send(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16);
      send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 48);

      // Reset mid-read with byte mode selected beforehand.
      send(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16);
      send(8'h02, 8'h00, 8'h01, 8'h00, 8'hAB, 8'hCD, 48);
      tx_q.delete();
      tx_q.push_back(8'h03); tx_q.push_back(8'h00); tx_q.push_back(8'h12); tx_q.push_back(8'h34);
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         cs_n = 1'b0;
         d = tx_q[k / 8];
         mosi = d[7 - (k % 8)];
         @(posedge clk);
      end
      #2 arst_n = 1'b0;
      #1 check("reset_mid_outputs", 64'({miso, mem_en, mem_wr, mem_addr, mem_wdata}), 64'(0));
      cs_n = 1'b1;
      tx_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      mode_m = 8'h40;
      send(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24);
      send(8'h03, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 48);

      for (int t = 0; t < 200; t++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: cmd = 8'h03;
            3, 4, 5: cmd = 8'h02;
            6:       cmd = 8'h05;
            7:       cmd = 8'h01;
            default: cmd = 8'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       base = 24'($urandom);
            1:       base = 24'hFFFFFF - 24'($urandom_range(0, 3));
            2:       base = {19'($urandom), 5'h1F - 5'($urandom_range(0, 2))};
            default: base = 24'($urandom_range(0, 63));
         endcase
         tx_q.delete();
         tx_q.push_back(cmd);
         tx_q.push_back(base[23:16]); tx_q.push_back(base[15:8]); tx_q.push_back(base[7:0]);
         nbytes = $urandom_range(1, 8);
         nb = 8 * nbytes;
         if ($urandom_range(0, 3) == 0) nb = nb - $urandom_range(1, 7);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         xfer(nb);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
